adc_capture_ctrl: RTL and testbench

- Host-side controller for the external 8-bit ADC on the GPIO_0 pinout (TRIGGER, RESET, DATA, DVALID, BUSY).
- On a start request from the PULPino PIO/bus glue, it runs one conversion handshake and captures the word into a small sample FIFO.
- Raises a level interrupt toward the core's event unit.
- Sits directly upstream of the ADC: it drives the ADC's trigger/reset and consumes its data/valid/busy.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_sample_fifo.sv | 63 ++++++
 rtl/adc_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and default sizes for the ADC capture controller.
package adc_pkg;

  localparam int unsigned ADC_WORD_SIZE  = 8;
  localparam int unsigned ADC_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADC_RST,
    TRIG,
    WAIT_VALID,
    CAPTURE
  } adc_state_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous show-ahead sample FIFO; a pop and a push in the same cycle both
// take effect, so a full FIFO still accepts a push alongside a pop.
module adc_sample_fifo
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_WORD_SIZE,
  parameter int unsigned DEPTH = ADC_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/adc_capture_ctrl.sv
// Host-side controller for the external 8-bit ADC: runs one trigger/DVALID
// handshake per start request and stores the captured word in a sample FIFO.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = ADC_WORD_SIZE,
  parameter int unsigned FIFO_DEPTH  = ADC_FIFO_DEPTH,
  parameter int unsigned TRIG_CYCLES = 2,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned TIMEOUT     = 500,
  parameter int unsigned IRQ_THRESH  = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start_i,
  input  logic                         adc_rst_req_i,
  input  logic                         clr_status_i,
  input  logic                         rd_en_i,
  input  logic [WORD_SIZE-1:0]         adc_data_i,
  input  logic                         adc_dvalid_i,
  input  logic                         adc_busy_i,
  output logic                         adc_trigger_o,
  output logic                         adc_reset_o,
  output logic [WORD_SIZE-1:0]         rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         fifo_empty_o,
  output logic                         fifo_full_o,
  output logic                         busy_o,
  output logic                         timeout_o,
  output logic                         overflow_o,
  output logic                         irq_o
);

  localparam int unsigned CNT_MAX = (TIMEOUT > RST_CYCLES)
                                    ? ((TIMEOUT > TRIG_CYCLES) ? TIMEOUT : TRIG_CYCLES)
                                    : ((RST_CYCLES > TRIG_CYCLES) ? RST_CYCLES : TRIG_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;

  adc_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 trig_q, trig_d;
  logic                 arst_q, arst_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 overflow_q, overflow_d;
  logic                 irq_q, irq_d;
  logic                 push;
  logic                 timeout_set;
  logic                 overflow_set;

  // BUSY from the ADC is status only; nothing in the handshake waits on it.
  logic unused_adc_busy;
  assign unused_adc_busy = adc_busy_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    push         = 1'b0;
    timeout_set  = 1'b0;
    overflow_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (adc_rst_req_i)  state_d = ADC_RST;
        else if (start_i)   state_d = TRIG;
      end
      ADC_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          state_d = WAIT_VALID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_VALID: begin
        // DVALID on the last count still wins over the timeout.
        if (adc_dvalid_i) begin
          data_d  = adc_data_i;
          state_d = CAPTURE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        // A same-cycle pop frees a slot before the write lands.
        if (!fifo_full_o || rd_en_i) push = 1'b1;
        else                         overflow_set = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    trig_d     = (state_d == TRIG);
    arst_d     = (state_d == ADC_RST);
    busy_d     = (state_d != IDLE);
    timeout_d  = timeout_set  | (timeout_q  & ~clr_status_i);
    overflow_d = overflow_set | (overflow_q & ~clr_status_i);
    irq_d      = (fifo_count_o >= FCNT_W'(IRQ_THRESH)) | timeout_q | overflow_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      trig_q     <= 1'b0;
      arst_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      trig_q     <= trig_d;
      arst_q     <= arst_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  adc_sample_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push),
    .pop_i   (rd_en_i),
    .data_i  (data_q),
    .data_o  (rd_data_o),
    .count_o (fifo_count_o),
    .empty_o (fifo_empty_o),
    .full_o  (fifo_full_o)
  );

  assign adc_trigger_o = trig_q;
  assign adc_reset_o   = arst_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;
  assign overflow_o    = overflow_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: per-cycle vector table plus multi-cycle sequences
// driven by a small ADC model that answers a trigger after a fixed delay.
module tb_adc_capture_ctrl;
  import adc_pkg::*;

  localparam int unsigned MOCK_DELAY = 5;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start_i, adc_rst_req_i, clr_status_i, rd_en_i;
  logic [7:0] adc_data_i;
  logic       adc_dvalid_i, adc_busy_i;
  logic       adc_trigger_o, adc_reset_o;
  logic [7:0] rd_data_o;
  logic [3:0] fifo_count_o;
  logic       fifo_empty_o, fifo_full_o, busy_o, timeout_o, overflow_o, irq_o;

  logic       use_mock, mock_enable, mock_dvalid, mock_pending, trig_prev;
  logic [7:0] mock_data;
  int         mock_cnt;
  logic       tb_dvalid;
  logic [7:0] tb_data;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  assign adc_dvalid_i = use_mock ? mock_dvalid : tb_dvalid;
  assign adc_data_i   = use_mock ? mock_data   : tb_data;
  assign adc_busy_i   = use_mock & mock_pending;

  adc_capture_ctrl #(
    .WORD_SIZE(8), .FIFO_DEPTH(8), .TRIG_CYCLES(2),
    .RST_CYCLES(4), .TIMEOUT(500), .IRQ_THRESH(1)
  ) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .adc_rst_req_i(adc_rst_req_i),
    .clr_status_i(clr_status_i), .rd_en_i(rd_en_i), .adc_data_i(adc_data_i),
    .adc_dvalid_i(adc_dvalid_i), .adc_busy_i(adc_busy_i),
    .adc_trigger_o(adc_trigger_o), .adc_reset_o(adc_reset_o),
    .rd_data_o(rd_data_o), .fifo_count_o(fifo_count_o),
    .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .overflow_o(overflow_o), .irq_o(irq_o)
  );

  // ADC model: one DVALID pulse MOCK_DELAY cycles after TRIGGER falls.
  always @(negedge CLK) begin
    mock_dvalid = 1'b0;
    if (RST) begin
      mock_pending = 1'b0;
    end else if (mock_pending) begin
      if (mock_cnt == 0) begin
        mock_dvalid  = mock_enable;
        mock_pending = 1'b0;
      end else begin
        mock_cnt = mock_cnt - 1;
      end
    end
    if (trig_prev && !adc_trigger_o) begin
      mock_pending = 1'b1;
      mock_cnt     = MOCK_DELAY - 1;
    end
    trig_prev = adc_trigger_o;
  end

  typedef struct {
    logic       st, rr, clr, rd, dv;
    logic [7:0] data;
    logic       e_trig, e_arst, e_busy, e_empty, e_irq, chk_data;
    logic [3:0] e_count;
    logic [7:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic st, rr, clr, rd, dv, input logic [7:0] data,
                              input logic e_trig, e_arst, e_busy,
                              input logic [3:0] e_count, input logic e_empty, e_irq,
                              input logic chk_data, input logic [7:0] e_data);
    vec_t v;
    v.st = st; v.rr = rr; v.clr = clr; v.rd = rd; v.dv = dv; v.data = data;
    v.e_trig = e_trig; v.e_arst = e_arst; v.e_busy = e_busy; v.e_count = e_count;
    v.e_empty = e_empty; v.e_irq = e_irq; v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; adc_rst_req_i = 1'b0; clr_status_i = 1'b0; rd_en_i = 1'b0;
    tb_dvalid = 1'b0; tb_data = 8'h00;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 200) begin
      step();
      n++;
    end
    chk(name, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_count(input string name);
    int n = 0;
    while (fifo_count_o == 4'd0 && n < 50) begin
      step();
      n++;
    end
    chk(name, 32'(fifo_count_o), 32'd1);
  endtask

  vec_t       vecs [15];
  logic [7:0] drain_exp [8];

  initial begin
    int n;
    idle_inputs();
    use_mock = 1'b0; mock_enable = 1'b1; mock_data = 8'h00;
    mock_dvalid = 1'b0; mock_pending = 1'b0; trig_prev = 1'b0; mock_cnt = 0;
    RST = 1'b1;
    #12;
    chk("rst_trig",  32'(adc_trigger_o), 32'd0);
    chk("rst_arst",  32'(adc_reset_o),   32'd0);
    chk("rst_count", 32'(fifo_count_o),  32'd0);
    chk("rst_empty", 32'(fifo_empty_o),  32'd1);
    chk("rst_irq",   32'(irq_o),         32'd0);
    chk("rst_busy",  32'(busy_o),        32'd0);
    RST = 1'b0;
    step();

    //            st rr cl rd dv data  | trg ars bsy cnt emp irq chk edata
    vecs[0]  = mk(1, 1, 0, 0, 0, 8'h00,  0, 1, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 0, 0, 8'h00,  0, 1, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[2]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 1, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[3]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 1, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[4]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 4'd0, 1, 0, 0, 8'h00);
    vecs[5]  = mk(1, 0, 0, 0, 0, 8'h00,  1, 0, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[6]  = mk(0, 0, 0, 0, 1, 8'hAA,  1, 0, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[7]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[8]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[9]  = mk(0, 0, 0, 0, 1, 8'h5A,  0, 0, 1, 4'd0, 1, 0, 0, 8'h00);
    vecs[10] = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 4'd1, 0, 0, 1, 8'h5A);
    vecs[11] = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 4'd1, 0, 1, 1, 8'h5A);
    vecs[12] = mk(0, 0, 0, 1, 0, 8'h00,  0, 0, 0, 4'd0, 1, 1, 0, 8'h00);
    vecs[13] = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 4'd0, 1, 0, 0, 8'h00);
    vecs[14] = mk(0, 0, 0, 1, 0, 8'h00,  0, 0, 0, 4'd0, 1, 0, 0, 8'h00);

    for (int i = 0; i < 15; i++) begin
      start_i = vecs[i].st; adc_rst_req_i = vecs[i].rr; clr_status_i = vecs[i].clr;
      rd_en_i = vecs[i].rd; tb_dvalid = vecs[i].dv; tb_data = vecs[i].data;
      step();
      chk($sformatf("v%0d_trig", i),  32'(adc_trigger_o), 32'(vecs[i].e_trig));
      chk($sformatf("v%0d_arst", i),  32'(adc_reset_o),   32'(vecs[i].e_arst));
      chk($sformatf("v%0d_busy", i),  32'(busy_o),        32'(vecs[i].e_busy));
      chk($sformatf("v%0d_count", i), 32'(fifo_count_o),  32'(vecs[i].e_count));
      chk($sformatf("v%0d_empty", i), 32'(fifo_empty_o),  32'(vecs[i].e_empty));
      chk($sformatf("v%0d_irq", i),   32'(irq_o),         32'(vecs[i].e_irq));
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), 32'(rd_data_o), 32'(vecs[i].e_data));
    end
    idle_inputs();

    // Single conversion through the ADC model.
    do_reset();
    use_mock = 1'b1; mock_enable = 1'b1; mock_data = 8'h3C;
    pulse_start();
    chk("a_trig0", 32'(adc_trigger_o), 32'd1);
    step();
    chk("a_trig1", 32'(adc_trigger_o), 32'd1);
    step();
    chk("a_trig2", 32'(adc_trigger_o), 32'd0);
    wait_count("a_count");
    chk("a_data", 32'(rd_data_o), 32'h3C);
    chk("a_irq_lag", 32'(irq_o), 32'd0);
    step();
    chk("a_irq", 32'(irq_o), 32'd1);

    // Nine conversions with no reads: eighth fills, ninth overflows.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mock_data = 8'(8'h10 + i);
      pulse_start();
      wait_idle($sformatf("b_idle%0d", i));
      if (i == 7) begin
        chk("b_full8", 32'(fifo_full_o), 32'd1);
        chk("b_ovf8",  32'(overflow_o),  32'd0);
      end
    end
    chk("b_count", 32'(fifo_count_o), 32'd8);
    chk("b_full",  32'(fifo_full_o),  32'd1);
    chk("b_ovf",   32'(overflow_o),   32'd1);
    chk("b_head",  32'(rd_data_o),    32'h10);
    clr_status_i = 1'b1;
    step();
    clr_status_i = 1'b0;
    chk("b_ovf_clr", 32'(overflow_o), 32'd0);
    chk("b_irq_clr", 32'(irq_o), 32'd1);
    step();
    chk("b_irq_hold", 32'(irq_o), 32'd1);

    // Capture into a full FIFO in the same cycle as a pop.
    use_mock = 1'b0;
    pulse_start();
    step();
    step();
    tb_dvalid = 1'b1; tb_data = 8'h99;
    step();
    tb_dvalid = 1'b0;
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("c_count", 32'(fifo_count_o), 32'd8);
    chk("c_ovf",   32'(overflow_o),   32'd0);
    chk("c_full",  32'(fifo_full_o),  32'd1);
    chk("c_head",  32'(rd_data_o),    32'h11);
    for (int k = 0; k < 8; k++) drain_exp[k] = (k < 7) ? 8'(8'h11 + k) : 8'h99;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("c_drain%0d", k), 32'(rd_data_o), 32'(drain_exp[k]));
      rd_en_i = 1'b1;
      step();
      rd_en_i = 1'b0;
    end
    chk("c_empty", 32'(fifo_empty_o), 32'd1);
    chk("c_count0", 32'(fifo_count_o), 32'd0);

    // DVALID never arrives: timeout TRIG_CYCLES+TIMEOUT cycles after start.
    do_reset();
    use_mock = 1'b1; mock_enable = 1'b0;
    pulse_start();
    n = 0;
    while (!timeout_o && n < 600) begin
      step();
      n++;
    end
    chk("d_latency", 32'(n), 32'd502);
    chk("d_busy",  32'(busy_o),       32'd0);
    chk("d_count", 32'(fifo_count_o), 32'd0);
    step();
    chk("d_irq", 32'(irq_o), 32'd1);
    clr_status_i = 1'b1;
    step();
    clr_status_i = 1'b0;
    chk("d_clr", 32'(timeout_o), 32'd0);
    mock_enable = 1'b1;

    // DVALID on the final wait cycle is still accepted.
    use_mock = 1'b0;
    pulse_start();
    step();
    step();
    repeat (499) step();
    chk("e_no_tmo_yet", 32'(timeout_o), 32'd0);
    tb_dvalid = 1'b1; tb_data = 8'h77;
    step();
    tb_dvalid = 1'b0;
    step();
    chk("e_tmo",   32'(timeout_o),    32'd0);
    chk("e_count", 32'(fifo_count_o), 32'd1);
    chk("e_data",  32'(rd_data_o),    32'h77);

    // Asynchronous reset while waiting for DVALID, then while triggering.
    use_mock = 1'b1; mock_data = 8'hC5;
    pulse_start();
    step();
    step();
    step();
    #2 RST = 1'b1;
    #1;
    chk("f_busy",  32'(busy_o),       32'd0);
    chk("f_count", 32'(fifo_count_o), 32'd0);
    chk("f_empty", 32'(fifo_empty_o), 32'd1);
    chk("f_irq",   32'(irq_o),        32'd0);
    #2 RST = 1'b0;
    step();
    pulse_start();
    chk("f_trig_on", 32'(adc_trigger_o), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("f_trig_off", 32'(adc_trigger_o), 32'd0);
    #2 RST = 1'b0;
    step();
    pulse_start();
    wait_count("f_recap");
    chk("f_data", 32'(rd_data_o), 32'hC5);
    chk("f_tmo",  32'(timeout_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
